ps2_host_tx: RTL



---
 rtl/ps2_host_tx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 frame transmitter driving low-only line enables.
// Define PS2_TX_RETRY_EN to resend a failed byte up to three more times.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 1432,
   parameter int unsigned TIMEOUT_CYCLES = 28636,
   parameter int unsigned RELEASE_CYCLES = 8
) (
   input  logic       clk14,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_din_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CMAX =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(CMAX + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t INH_LAST = cnt_t'(INHIBIT_CYCLES - 1);
   localparam cnt_t TO_LAST  = cnt_t'(TIMEOUT_CYCLES - 1);
   localparam cnt_t REL      = cnt_t'(RELEASE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_DATA,
      S_ACK,
      S_WAIT
   } state_t;

   state_t     state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [8:0] frame_q, frame_d;
   logic       ack_fail_q, ack_fail_d;
   logic       clk_oe_q, clk_oe_d;
   logic       dat_oe_q, dat_oe_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
`ifdef PS2_TX_RETRY_EN
   logic [1:0] retry_q, retry_d;
`endif

   logic [1:0] clk_sync_q;
   logic [1:0] dat_sync_q;
   logic       clk_prev_q;
   logic       fall;
   logic       to_hit;
   logic       finish;
   logic       fail;

   assign fall   = clk_prev_q & ~clk_sync_q[1];
   assign to_hit = (cnt_q == TO_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      frame_d    = frame_q;
      ack_fail_d = ack_fail_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      finish     = 1'b0;
      fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d    = retry_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               frame_d  = {~^tx_data, tx_data};
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               dat_oe_d = 1'b0;
               cnt_d    = '0;
               bit_d    = '0;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = '0;
`endif
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d    = '0;
               bit_d    = '0;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               state_d  = S_REQ;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_REQ: begin
            // Edges right after clock release are line ringing, not the device.
            if (fall && cnt_q >= REL) begin
               cnt_d    = '0;
               dat_oe_d = ~frame_q[0];
               bit_d    = 4'd1;
               state_d  = S_DATA;
            end else if (to_hit) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_DATA: begin
            if (fall) begin
               cnt_d = '0;
               if (bit_q == 4'd9) begin
                  dat_oe_d = 1'b0;
                  state_d  = S_ACK;
               end else begin
                  dat_oe_d = ~frame_q[bit_q];
                  bit_d    = bit_q + 4'd1;
               end
            end else if (to_hit) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_ACK: begin
            if (fall) begin
               cnt_d      = '0;
               ack_fail_d = dat_sync_q[1];
               state_d    = S_WAIT;
            end else if (to_hit) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_WAIT: begin
            if (clk_sync_q[1] && dat_sync_q[1]) begin
               finish = 1'b1;
               fail   = ack_fail_q;
            end else if (fall) begin
               cnt_d = '0;
            end else if (to_hit) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         cnt_d    = '0;
         bit_d    = '0;
`ifdef PS2_TX_RETRY_EN
         if (fail && retry_q != 2'd3) begin
            retry_d  = retry_q + 2'd1;
            clk_oe_d = 1'b1;
            state_d  = S_INHIBIT;
         end else begin
            retry_d = '0;
            done_d  = 1'b1;
            err_d   = fail;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
`else
         done_d  = 1'b1;
         err_d   = fail;
         busy_d  = 1'b0;
         state_d = S_IDLE;
`endif
      end
   end

   always_ff @(posedge clk14) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         frame_q    <= '0;
         ack_fail_q <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         ack_fail_q <= ack_fail_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q <= {dat_sync_q[0], ps2_din_in};
         clk_prev_q <= clk_sync_q[1];
`ifdef PS2_TX_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign tx_ready   = (state_q == S_IDLE);
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
